// File: rtl/gate_sweep_checker_if.sv
// rtl/gate_sweep_checker_if.sv - stimulus/result bundle between the sweep checker and the gate block side
interface gate_sweep_checker_if #(
  parameter int ERR_W = 5
);
  logic             start;
  logic             a_out;
  logic             b_out;
  logic             or_in;
  logic             and_in;
  logic             xor_in;
  logic             not_in;
  logic             xnor_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [3:0]       fail_mask;
  logic [4:0]       err_gates;
  logic [ERR_W-1:0] err_count;

  modport master (
    input  start, or_in, and_in, xor_in, not_in, xnor_in,
    output a_out, b_out, busy, done, pass, fail_mask, err_gates, err_count
  );

  modport slave (
    output start, or_in, and_in, xor_in, not_in, xnor_in,
    input  a_out, b_out, busy, done, pass, fail_mask, err_gates, err_count
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - sweeps all four {a,b} vectors into a gate block and checks its five results
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input logic                  clock,
  input logic                  reset_n,
  gate_sweep_checker_if.master bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0]       fail_mask_q, fail_mask_d;
  logic [4:0]       err_gates_q, err_gates_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]       v_q, v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0]       expected, returned, mis;
  logic [2:0]       n_mis;
  logic [ERR_W+3:0] sum;
  logic [1:0]       v_next;

  // Bit order matches err_gates: or, and, xor, not, xnor
  always_comb begin
    expected = {~(a_q ^ b_q), ~a_q, a_q ^ b_q, a_q & b_q, a_q | b_q};
    returned = {bus.xnor_in, bus.not_in, bus.xor_in, bus.and_in, bus.or_in};
    mis   = '0;
    n_mis = '0;
    for (int i = 0; i < 5; i++) begin
      mis[i] = (returned[i] != expected[i]);
      if (mis[i]) n_mis = n_mis + 3'd1;
    end
    sum    = {4'b0, err_cnt_q} + (ERR_W+4)'(n_mis);
    v_next = v_q + 2'd1;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    err_gates_d = err_gates_q;
    err_cnt_d   = err_cnt_q;
    v_d         = v_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          v_d         = 2'd0;
          a_d         = 1'b0;
          b_d         = 1'b0;
          fail_mask_d = '0;
          err_gates_d = '0;
          err_cnt_d   = '0;
          pass_d      = 1'b0;
          cnt_d       = CNT_RELOAD;
          busy_d      = 1'b1;
          state_d     = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_SAMPLE: begin
        err_gates_d = err_gates_q | mis;
        if (sum > {4'b0, {ERR_W{1'b1}}}) err_cnt_d = '1;
        else                             err_cnt_d = sum[ERR_W-1:0];
        if (mis != '0) fail_mask_d[v_q] = 1'b1;
        if (v_q == 2'd3) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_cnt_d == '0);
          a_d     = 1'b0;
          b_d     = 1'b0;
          state_d = S_DONE;
        end else begin
          v_d     = v_next;
          a_d     = v_next[1];
          b_d     = v_next[0];
          cnt_d   = CNT_RELOAD;
          state_d = S_SETTLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
      err_gates_q <= '0;
      err_cnt_q   <= '0;
      v_q         <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      err_gates_q <= err_gates_d;
      err_cnt_q   <= err_cnt_d;
      v_q         <= v_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fail_mask_q;
  assign bus.err_gates = err_gates_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - directed bench for gate_sweep_checker with a configurable faulty gate model
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic stuck_not, swap_xx;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  gate_sweep_checker_if #(.ERR_W(5)) bus1 ();
  gate_sweep_checker_if #(.ERR_W(2)) bus2 ();

  gate_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(5)) u_dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus1)
  );

  gate_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(2)) u_dut_sat (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus2)
  );

  // Gate block model with injectable faults; the second instance sees every output inverted
  assign bus1.or_in   = bus1.a_out | bus1.b_out;
  assign bus1.and_in  = bus1.a_out & bus1.b_out;
  assign bus1.xor_in  = swap_xx ? ~(bus1.a_out ^ bus1.b_out) : (bus1.a_out ^ bus1.b_out);
  assign bus1.xnor_in = swap_xx ? (bus1.a_out ^ bus1.b_out) : ~(bus1.a_out ^ bus1.b_out);
  assign bus1.not_in  = stuck_not ? 1'b0 : ~bus1.a_out;

  assign bus2.or_in   = ~(bus2.a_out | bus2.b_out);
  assign bus2.and_in  = ~(bus2.a_out & bus2.b_out);
  assign bus2.xor_in  = ~(bus2.a_out ^ bus2.b_out);
  assign bus2.xnor_in = bus2.a_out ^ bus2.b_out;
  assign bus2.not_in  = bus2.a_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_sweep(output int bc, output int dc, output logic [7:0] sq, output logic ok);
    logic [1:0] lv;
    logic       hv;
    bc = 0; dc = 0; sq = '0; ok = 1'b0; lv = '0; hv = 1'b0;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus1.busy) begin
        bc++;
        if (!hv || lv != {bus1.a_out, bus1.b_out}) begin
          sq = {sq[5:0], bus1.a_out, bus1.b_out};
          lv = {bus1.a_out, bus1.b_out};
          hv = 1'b1;
        end
      end
      if (bus1.done) dc++;
      if (dc > 0 && !bus1.done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  int         bc, dc, cnt;
  logic [7:0] sq;
  logic       ok;
  logic       bz [1:40];
  logic       dn [1:40];
  logic       ps [1:40];
  logic [4:0] ec [1:40];
  logic [3:0] fm [1:40];

  initial begin
    rst_n = 1'b0; bus1.start = 1'b0; bus2.start = 1'b0;
    stuck_not = 1'b0; swap_xx = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ab",       {30'd0, bus1.a_out, bus1.b_out}, 32'd0);
    chk("rst_busy_done",{30'd0, bus1.busy, bus1.done}, 32'd0);
    chk("rst_pass",     {31'd0, bus1.pass}, 32'd0);
    chk("rst_results",  {18'd0, bus1.fail_mask, bus1.err_gates, bus1.err_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: healthy gate block
    run_sweep(bc, dc, sq, ok);
    chk("t1_complete",  {31'd0, ok}, 32'd1);
    chk("t1_busy_len",  bc, 32'd12);
    chk("t1_done_len",  dc, 32'd1);
    chk("t1_order",     {24'd0, sq}, 32'h1B);
    chk("t1_pass",      {31'd0, bus1.pass}, 32'd1);
    chk("t1_results",   {18'd0, bus1.fail_mask, bus1.err_gates, bus1.err_count}, 32'd0);

    // 2: not_in stuck at 0
    stuck_not = 1'b1;
    run_sweep(bc, dc, sq, ok);
    chk("t2_complete",  {31'd0, ok}, 32'd1);
    chk("t2_fail_mask", {28'd0, bus1.fail_mask}, 32'h3);
    chk("t2_err_gates", {27'd0, bus1.err_gates}, 32'h08);
    chk("t2_err_count", {27'd0, bus1.err_count}, 32'd2);
    chk("t2_pass",      {31'd0, bus1.pass}, 32'd0);
    stuck_not = 1'b0;

    // 3: xor/xnor swapped
    swap_xx = 1'b1;
    run_sweep(bc, dc, sq, ok);
    chk("t3_complete",  {31'd0, ok}, 32'd1);
    chk("t3_fail_mask", {28'd0, bus1.fail_mask}, 32'hF);
    chk("t3_err_gates", {27'd0, bus1.err_gates}, 32'h14);
    chk("t3_err_count", {27'd0, bus1.err_count}, 32'd8);
    swap_xx = 1'b0;

    // 6: saturating counter with every returned output inverted
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus2.done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("t6_complete",  {31'd0, ok}, 32'd1);
    chk("t6_err_count", {30'd0, bus2.err_count}, 32'd3);
    chk("t6_err_gates", {27'd0, bus2.err_gates}, 32'h1F);
    chk("t6_fail_mask", {28'd0, bus2.fail_mask}, 32'hF);
    chk("t6_pass",      {31'd0, bus2.pass}, 32'd0);
    @(negedge clk);

    // 4: start held 40 cycles; first sweep faulty, second healthy
    stuck_not = 1'b1;
    bus1.start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bz[c] = bus1.busy; dn[c] = bus1.done; ps[c] = bus1.pass;
      ec[c] = bus1.err_count; fm[c] = bus1.fail_mask;
      if (c == 13) stuck_not = 1'b0;
    end
    bus1.start = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 40; c++) if (dn[c]) cnt++;
    chk("t4_done_count", cnt, 32'd2);
    chk("t4_done_pos",   {30'd0, dn[13], dn[27]}, 32'd3);
    cnt = 0;
    for (int c = 1; c <= 12; c++) if (bz[c]) cnt++;
    chk("t4_busy_run",   cnt, 32'd12);
    chk("t4_idle_gap",   {29'd0, bz[13], bz[14], dn[14]}, 32'd0);
    chk("t4_restart",    {31'd0, bz[15]}, 32'd1);
    chk("t4_first_res",  {26'd0, ps[13], ec[13]}, 32'd2);
    chk("t4_cleared",    {23'd0, ec[15], fm[15]}, 32'd0);
    chk("t4_second_res", {26'd0, ps[27], ec[27]}, 32'h20);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus1.done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("t4_third_done", {31'd0, ok}, 32'd1);
    @(negedge clk);

    // 5: asynchronous reset during v=2 settle
    stuck_not = 1'b1;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_pre_ab",    {30'd0, bus1.a_out, bus1.b_out}, 32'd2);
    chk("t5_pre_mask",  {27'd0, bus1.busy, bus1.fail_mask}, 32'h13);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_ab",  {30'd0, bus1.a_out, bus1.b_out}, 32'd0);
    chk("t5_async_st",  {26'd0, bus1.busy, bus1.done, bus1.fail_mask}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stuck_not = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus1.busy || bus1.done) cnt++;
    end
    chk("t5_no_activity", cnt, 32'd0);
    run_sweep(bc, dc, sq, ok);
    chk("t5_new_sweep", {31'd0, ok}, 32'd1);
    chk("t5_new_result", {25'd0, bus1.pass, bc[5:0]}, 32'h4C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
